// File: rtl/i2s_frame_if_if.sv
// I2S frame port bundle: rx samples and DIN in, clocks, DOUT and tx words out.
// master = framer side, slave = host/bench side.
interface i2s_frame_if_if;
    logic [23:0] rx_real;
    logic [23:0] rx_imag;
    logic        DIN;
    logic        BCLK;
    logic        LRCLK;
    logic        DOUT;
    logic [15:0] tx_real;
    logic [15:0] tx_imag;
    logic        tx_strobe;

    modport master (
        input  rx_real, rx_imag, DIN,
        output BCLK, LRCLK, DOUT, tx_real, tx_imag, tx_strobe
    );
    modport slave (
        output rx_real, rx_imag, DIN,
        input  BCLK, LRCLK, DOUT, tx_real, tx_imag, tx_strobe
    );
endinterface

// File: rtl/i2s_frame_if.sv
// I2S master framer: 64-BCLK frames, 24-bit rx out on DOUT, 16-bit tx in from DIN.
// Define I2S_LOOPBACK_EN to feed the DIN sampler from the registered DOUT.
module i2s_frame_if #(
    parameter int BCLK_DIV = 4
) (
    input  logic          SAICLK,
    input  logic          reset,
    i2s_frame_if_if.master bus
);
    localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF = DW'(BCLK_DIV / 2);
    localparam logic [DW-1:0] D_RISE = DW'(BCLK_DIV / 2 - 1);

    logic [DW-1:0] d_q, d_d;
    logic [5:0]    b_q, b_d;
    logic          bclk_q, bclk_d, lrclk_q, lrclk_d, dout_q, dout_d;
    logic [23:0]   left_q, left_d, right_q, right_d;
    logic [15:0]   din_q, din_d, stage_q, stage_d;
    logic          pend_q, pend_d;
    logic [15:0]   tx_real_q, tx_real_d, tx_imag_q, tx_imag_d;
    logic          tx_strobe_q, tx_strobe_d;
    logic          d_wrap, sin;

    assign d_wrap = (d_q == D_LAST);

`ifdef I2S_LOOPBACK_EN
    logic unused_din;
    assign unused_din = bus.DIN;
    assign sin        = dout_q;
`else
    assign sin        = bus.DIN;
`endif

    always_comb begin
        d_d         = d_wrap ? '0 : d_q + 1'b1;
        b_d         = d_wrap ? b_q + 6'd1 : b_q;
        bclk_d      = (d_d >= D_HALF);
        lrclk_d     = b_d[5];
        dout_d      = dout_q;
        left_d      = left_q;
        right_d     = right_q;
        din_d       = din_q;
        stage_d     = stage_q;
        pend_d      = 1'b0;
        tx_real_d   = tx_real_q;
        tx_imag_d   = tx_imag_q;
        tx_strobe_d = pend_q;

        // DOUT moves only on the BCLK falling edge (divider wrap), one BCLK after LRCLK.
        if (d_wrap) begin
            dout_d = 1'b0;
            if (b_q == 6'd63) begin
                left_d  = bus.rx_real;
                right_d = bus.rx_imag;
            end else if (b_d[4:0] != 5'd0 && b_d[4:0] <= 5'd24) begin
                if (b_d[5]) begin
                    dout_d  = right_q[23];
                    right_d = {right_q[22:0], 1'b0};
                end else begin
                    dout_d  = left_q[23];
                    left_d  = {left_q[22:0], 1'b0};
                end
            end
        end

        // Capture on the BCLK rising edge; only positions 1..16 carry tx bits.
        if (d_q == D_RISE && b_q[4:0] != 5'd0 && b_q[4:0] <= 5'd16) begin
            din_d = {din_q[14:0], sin};
            if (b_q[4:0] == 5'd16) begin
                if (b_q[5]) pend_d  = 1'b1;
                else        stage_d = {din_q[14:0], sin};
            end
        end

        if (pend_q) begin
            tx_real_d = stage_q;
            tx_imag_d = din_q;
        end
    end

    always_ff @(posedge SAICLK or negedge reset) begin
        if (!reset) begin
            d_q         <= '0;
            b_q         <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            dout_q      <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            din_q       <= '0;
            stage_q     <= '0;
            pend_q      <= 1'b0;
            tx_real_q   <= '0;
            tx_imag_q   <= '0;
            tx_strobe_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            b_q         <= b_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            dout_q      <= dout_d;
            left_q      <= left_d;
            right_q     <= right_d;
            din_q       <= din_d;
            stage_q     <= stage_d;
            pend_q      <= pend_d;
            tx_real_q   <= tx_real_d;
            tx_imag_q   <= tx_imag_d;
            tx_strobe_q <= tx_strobe_d;
        end
    end

    assign bus.BCLK      = bclk_q;
    assign bus.LRCLK     = lrclk_q;
    assign bus.DOUT      = dout_q;
    assign bus.tx_real   = tx_real_q;
    assign bus.tx_imag   = tx_imag_q;
    assign bus.tx_strobe = tx_strobe_q;
endmodule

// File: doc/i2s_frame_if.md
# i2s_frame_if

I2S master framing stage between the digital down/up converters and the external codec/MCU SAI port. It serializes one complex receive sample per frame (real = left, imag = right, 24-bit) onto DOUT, and deserializes one complex 16-bit transmit sample per frame from DIN for the Transmitter. It generates BCLK and LRCLK from SAICLK. Transmit words are presented with a one-cycle strobe.

## Interface
- BCLK_DIV, 4: SAICLK cycles per BCLK period; even, ≥2.
- SAICLK  in  1  master clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_real  in  24  receiver I sample, two's complement, sampled at frame start.
- rx_imag  in  24  receiver Q sample, two's complement, sampled at frame start.
- DIN  in  1  serial transmit audio from host.
- BCLK  out  1  bit clock, SAICLK/BCLK_DIV, 50 % duty.
- LRCLK  out  1  word select; 0 = left/real, 1 = right/imag.
- DOUT  out  1  serial receive data.
- tx_real  out  16  transmit I word, held between updates.
- tx_imag  out  16  transmit Q word, held between updates.
- tx_strobe  out  1  one-SAICLK pulse when tx_real/tx_imag update.

## Operation
- Divider d counts 0..BCLK_DIV-1. Bit counter b counts 0..63 and advances when d wraps. Frame = 64 BCLK, two 32-bit slots. Slot = b[5]; position p = b[4:0].
- BCLK = 1 while d ≥ BCLK_DIV/2, else 0. LRCLK = b[5].
- Frame start is b wrapping 63→0 (d wrapping). On that cycle, rx_real and rx_imag load into 24-bit left/right shift registers together.
- DOUT format: standard I2S, one BCLK delay. For p = 1..24, DOUT = word[24-p] (MSB first). For p = 0 and p = 25..31, DOUT = 0.
- DIN is sampled on BCLK rising edge. For p = 1..16, it shifts into a 16-bit register, MSB first. Bits at other positions are ignored.
- When left p = 16 is sampled, the word goes into a staging register; outputs are unchanged.
- When right p = 16 is sampled, on the following SAICLK edge:
  - tx_real ← staged left word;
  - tx_imag ← right word;
  - tx_strobe = 1 for exactly one cycle.
- Reset (async assert) sets:
  - d = 0, b = 0;
  - BCLK = 0, LRCLK = 0, DOUT = 0;
  - shift and staging registers = 0;
  - tx_real = 0, tx_imag = 0, tx_strobe = 0.
- After reset release, the first frame transmits zeros. Live rx data first appears after the first 63→0 wrap.
- Reset mid-frame aborts the frame. A partial tx word is never strobed.

## Timing
- BCLK, LRCLK and DOUT are registered and change on the same SAICLK edge.
- LRCLK and DOUT change only on the edge where BCLK goes 1→0.
- DIN is captured on the SAICLK edge where BCLK goes 0→1.
- Frame rate = f_SAICLK / (64·BCLK_DIV). Example: 12.288 MHz with BCLK_DIV = 4 gives 48 kHz.
- Rx latency: input sample at frame-start edge → MSB on DOUT one BCLK period later.
- Tx latency: right slot DIN bit 0 sampled → tx_strobe exactly one SAICLK later.
- tx_strobe occurs once per frame, with period exactly 64·BCLK_DIV SAICLK cycles.
- rx inputs are don't-care except on the frame-start edge.

## Configuration
- I2S_LOOPBACK_EN defined: the DIN sampler takes the internal registered DOUT instead of the DIN pin, and the DIN pin is ignored. Each tx word equals the top 16 bits of the rx word from the same frame:
  - tx_real = rx_real[23:8];
  - tx_imag = rx_imag[23:8].
- I2S_LOOPBACK_EN undefined: DIN pin is used and there is no internal path from DOUT to the sampler.

## Test plan
- Reset held low, SAICLK running → BCLK = LRCLK = DOUT = 0, tx_real = tx_imag = 0, tx_strobe never asserts; release → BCLK period 4 cycles, LRCLK period 256 cycles.
- rx_real = 24'hA5C3F0, rx_imag = 24'h800001 at frame start → DOUT slot left p1..24 = A5C3F0 MSB first, p0 and p25..31 = 0; right slot = 800001; LRCLK toggles only on BCLK falls.
- Host drives left 16'h1234, right 16'hFEDC (I2S, one-BCLK delay) → single tx_strobe one cycle after right p16 sample; tx_real = 1234, tx_imag = FEDC; both held until next strobe.
- Continuous frames → tx_strobe spacing exactly 256 SAICLK cycles; no strobe during the left slot.
- Reset asserted at b = 40 → all outputs zero immediately (async); no strobe for the aborted frame; next valid strobe only after a full new frame.
- I2S_LOOPBACK_EN, rx_real = 24'h7FFF00, rx_imag = 24'h00FF80 → tx_real = 7FFF, tx_imag = 00FF with strobe in the same frame; DIN toggling has no effect.
